// File: rtl/trigger_front.sv
// Input-conditioning front end: registers, gates and masks layer hits, then stretches each by the drift time.
// Latency: ly_in -> ly_m 1 clk, ly_m -> ly_ext 1 clk, ly_ext -> actv 1 clk.
// Backpressure: none; a new hit sample is accepted every clock.
//
// Ports:
//   clk, rst              single clock, synchronous active-high reset
//   ly_in, hc_mask        raw hits (layer 0 in LSBs) and static enable mask (1 = enabled)
//   input_disr, ext_trig_en, ext_trig2, inject, ext_inject2   input gating controls
//   drifttime, trig_stop  extension length in clocks and extension-stage freeze
//   auto_en, auto_clr, hot_thresh, win_len   hot-channel rate monitor controls
//   ly_m, ly_ext, actv    gated hits, extended hits, OR of extended hits
//   auto_mask, n_masked, win_done   sticky auto-mask, its population count, window-end pulse
//
// Build option: define TRIGGER_FRONT_AUTOMASK_EN to build the rate monitor and auto-mask.
// Without it auto_mask, n_masked and win_done are tied low and the monitor inputs are ignored.
module trigger_front #(
   parameter  int LAYERS = 6,
   parameter  int WIDTH  = 32,
   parameter  int EXT_W  = 3,
   parameter  int CNT_W  = 8,
   parameter  int WIN_W  = 16,
   localparam int N      = LAYERS * WIDTH,
   localparam int NM_W   = $clog2(N + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N-1:0]     ly_in,
   input  logic [N-1:0]     hc_mask,
   input  logic             input_disr,
   input  logic             ext_trig_en,
   input  logic             ext_trig2,
   input  logic             inject,
   input  logic             ext_inject2,
   input  logic [EXT_W-1:0] drifttime,
   input  logic             trig_stop,
   input  logic             auto_en,
   input  logic             auto_clr,
   input  logic [CNT_W-1:0] hot_thresh,
   input  logic [WIN_W-1:0] win_len,
   output logic [N-1:0]     ly_m,
   output logic [N-1:0]     ly_ext,
   output logic [N-1:0]     auto_mask,
   output logic [NM_W-1:0]  n_masked,
   output logic             win_done,
   output logic             actv
);

   logic             gate;
   logic [N-1:0]     raw_d;
   logic [N-1:0]     amask;          // auto-mask as seen by the gating path
   logic [N-1:0]     ly_m_d, ly_m_q;
   logic [N-1:0]     ly_m_prev_q;
   logic [N-1:0]     rise;
   logic [N-1:0]     ly_ext_d, ly_ext_q;
   logic [EXT_W-1:0] c_d [N];
   logic [EXT_W-1:0] c_q [N];
   logic             actv_q;

   // External trigger / inject modes block the inputs unless their companion enable is also set.
   always_comb begin
      gate   = !input_disr && !((ext_trig_en && !ext_trig2) || (inject && !ext_inject2));
      raw_d  = gate ? (ly_in & hc_mask) : '0;
      ly_m_d = raw_d & ~amask;
      rise   = ly_m_q & ~ly_m_prev_q;
   end

   // Per-channel extension counter. With drifttime 0 the counter never loads and ly_ext
   // simply follows ly_m one clock later. trig_stop freezes the whole stage.
   always_comb begin
      for (int i = 0; i < N; i++) begin
         c_d[i]      = c_q[i];
         ly_ext_d[i] = ly_ext_q[i];
         if (!trig_stop) begin
            if (rise[i])
               c_d[i] = drifttime;
            else if (c_q[i] != '0)
               c_d[i] = c_q[i] - EXT_W'(1);
            ly_ext_d[i] = (drifttime == '0) ? ly_m_q[i] : (c_d[i] != '0);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ly_m_q      <= '0;
         ly_m_prev_q <= '0;
         ly_ext_q    <= '0;
         actv_q      <= 1'b0;
         for (int i = 0; i < N; i++)
            c_q[i] <= '0;
      end else begin
         ly_m_q      <= ly_m_d;
         ly_m_prev_q <= trig_stop ? ly_m_prev_q : ly_m_q;
         ly_ext_q    <= ly_ext_d;
         actv_q      <= |ly_ext_q;
         for (int i = 0; i < N; i++)
            c_q[i] <= c_d[i];
      end
   end

   assign ly_m   = ly_m_q;
   assign ly_ext = ly_ext_q;
   assign actv   = actv_q;

`ifdef TRIGGER_FRONT_AUTOMASK_EN
   logic [N-1:0]     raw_q, raw_prev_q;
   logic [N-1:0]     raw_edge;
   logic [WIN_W-1:0] w_d, w_q;
   logic [CNT_W-1:0] h_d [N];
   logic [CNT_W-1:0] h_q [N];
   logic [N-1:0]     auto_mask_d, auto_mask_q;
   logic             win_done_d, win_done_q;
   logic [NM_W-1:0]  n_masked_d, n_masked_q;
   logic             win_end;

   // Edges are counted before the auto-mask so suppressed channels keep being measured.
   assign raw_edge = raw_q & ~raw_prev_q;
   // win_len 0 parks the window counter; a shortened window with w already past it
   // keeps counting and wraps through 2^WIN_W.
   assign win_end  = (win_len != '0) && (w_q == win_len - WIN_W'(1));

   always_comb begin
      w_d         = w_q;
      auto_mask_d = auto_mask_q;
      win_done_d  = 1'b0;
      for (int i = 0; i < N; i++)
         h_d[i] = h_q[i];
      if (auto_clr) begin
         // Clear wins over a coincident window end: nothing is set, no pulse.
         w_d         = '0;
         auto_mask_d = '0;
         for (int i = 0; i < N; i++)
            h_d[i] = '0;
      end else if (win_end) begin
         w_d        = '0;
         win_done_d = 1'b1;
         for (int i = 0; i < N; i++) begin
            if (auto_en && (hot_thresh != '0) && (h_q[i] >= hot_thresh))
               auto_mask_d[i] = 1'b1;
            h_d[i] = CNT_W'(raw_edge[i]);   // the edge in the closing cycle opens the next window
         end
      end else begin
         if (win_len != '0)
            w_d = w_q + WIN_W'(1);
         for (int i = 0; i < N; i++)
            if (raw_edge[i] && (h_q[i] != {CNT_W{1'b1}}))
               h_d[i] = h_q[i] + CNT_W'(1);
      end
   end

   always_comb begin
      n_masked_d = '0;
      for (int i = 0; i < N; i++)
         n_masked_d = n_masked_d + NM_W'(auto_mask_q[i]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         raw_q       <= '0;
         raw_prev_q  <= '0;
         w_q         <= '0;
         auto_mask_q <= '0;
         win_done_q  <= 1'b0;
         n_masked_q  <= '0;
         for (int i = 0; i < N; i++)
            h_q[i] <= '0;
      end else begin
         raw_q       <= raw_d;
         raw_prev_q  <= raw_q;
         w_q         <= w_d;
         auto_mask_q <= auto_mask_d;
         win_done_q  <= win_done_d;
         n_masked_q  <= n_masked_d;
         for (int i = 0; i < N; i++)
            h_q[i] <= h_d[i];
      end
   end

   assign amask     = auto_mask_q;
   assign auto_mask = auto_mask_q;
   assign n_masked  = n_masked_q;
   assign win_done  = win_done_q;
`else
   logic unused_monitor_cfg;
   assign unused_monitor_cfg = ^{auto_en, auto_clr, hot_thresh, win_len};

   assign amask     = '0;
   assign auto_mask = '0;
   assign n_masked  = '0;
   assign win_done  = 1'b0;
`endif

endmodule
